// File: rtl/pixel_frame_feeder_pkg.sv
// Shared WS2812 definitions: GRB pixel layout, default timing constants,
// feeder FSM state encoding and the per-channel brightness scale helper.
package ws2812_pkg;

    // Field order matches the wire order of a WS2812 pixel: G[23:16], R[15:8], B[7:0]
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    localparam int DEFAULT_REFRESH_CYCLES = 1_666_666;
    localparam int DEFAULT_GAP_CYCLES     = 2500;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LATCH  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    // (c * (b + 1)) >> 8; the product never exceeds 255 * 256, so 16 bits suffice
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return 8'(p >> 8);
    endfunction

endpackage

// File: rtl/pixel_frame_feeder_if.sv
// Pixel stream handshake between the frame feeder and a downstream serializer.
interface pixel_frame_feeder_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        pix_ready;

    modport master (output pix_valid, pix_data, pix_last, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface

// File: rtl/pixel_frame_feeder_scaler.sv
// Combinational global-brightness scaler for one GRB pixel.
// Only compiled with FEEDER_BRIGHTNESS_EN, the only build that instantiates it.
`ifdef FEEDER_BRIGHTNESS_EN
module pixel_scaler
    import ws2812_pkg::*;
(
    input  logic [23:0] color,
    input  logic [7:0]  bright,
    output logic [23:0] scaled
);
    grb_t c;
    grb_t s;

    assign c = grb_t'(color);

    always_comb begin
        s   = '0;
        s.g = scale_channel(c.g, bright);
        s.r = scale_channel(c.r, bright);
        s.b = scale_channel(c.b, bright);
    end

    assign scaled = s;
endmodule
`endif

// File: rtl/pixel_frame_feeder.sv
// Double-buffered WS2812 frame feeder: streams the active buffer every refresh
// period or on commit. Define FEEDER_BRIGHTNESS_EN to enable global brightness.
module pixel_frame_feeder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_addr,
    input  logic [23:0]                 wr_data,
    input  logic                        commit,
    input  logic [7:0]                  brightness,
    pixel_frame_feeder_if.master        pix,
    output logic                        frame_busy,
    output logic                        commit_pending
);
    localparam int AW         = $clog2(NUM_LEDS);
    localparam int unsigned N = NUM_LEDS;

    logic [23:0]   back   [NUM_LEDS];
    logic [23:0]   active [NUM_LEDS];
    state_t        state;
    logic [AW-1:0] idx;
    logic [31:0]   refresh_cnt;
    logic [31:0]   gap_cnt;
    logic          refresh_pending;
    logic          is_last;
    logic          streaming;
    logic [23:0]   cur_px;
    logic [23:0]   shown_px;

    assign streaming = (state == ST_STREAM);
    assign is_last   = (32'(idx) == N - 1);
    assign cur_px    = active[idx];

`ifdef FEEDER_BRIGHTNESS_EN
    logic [7:0] bright_q;

    pixel_scaler u_scaler (
        .color  (cur_px),
        .bright (bright_q),
        .scaled (shown_px)
    );
`else
    logic [7:0] unused_brightness;
    assign unused_brightness = brightness;
    assign shown_px          = cur_px;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            refresh_cnt     <= '0;
            gap_cnt         <= '0;
            refresh_pending <= 1'b0;
            commit_pending  <= 1'b0;
`ifdef FEEDER_BRIGHTNESS_EN
            bright_q        <= '0;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                back[i]   <= '0;
                active[i] <= '0;
            end
        end else begin
            if (wr_en && (32'(wr_addr) < N))
                back[wr_addr] <= wr_data;

            // A wrap coinciding with LATCH re-arms the request rather than losing it
            if (refresh_cnt == 32'(REFRESH_CYCLES - 1)) begin
                refresh_cnt     <= '0;
                refresh_pending <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 32'd1;
                if (state == ST_LATCH)
                    refresh_pending <= 1'b0;
            end

            if (commit)
                commit_pending <= 1'b1;
            else if (state == ST_LATCH)
                commit_pending <= 1'b0;

            case (state)
                // Raw commit also triggers so a commit in IDLE reaches LATCH next cycle
                ST_IDLE: begin
                    if (refresh_pending || commit_pending || commit)
                        state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (commit_pending) begin
                        for (int unsigned i = 0; i < N; i++)
                            active[i] <= back[i];
                    end
                    idx      <= '0;
`ifdef FEEDER_BRIGHTNESS_EN
                    bright_q <= brightness;
`endif
                    state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (pix.pix_ready) begin
                        if (is_last) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 32'(GAP_CYCLES - 1))
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 32'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pix.pix_valid = streaming;
    assign pix.pix_last  = streaming && is_last;
    assign pix.pix_data  = streaming ? shown_px : '0;
    assign frame_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Directed self-checking bench for pixel_frame_feeder (main instance plus a
// short-refresh instance); expectations follow FEEDER_BRIGHTNESS_EN.
module tb_pixel_frame_feeder;
    logic        clk = 1'b0;
    logic        rst, rst_r;
    logic        wr_en, wr_en_r;
    logic [2:0]  wr_addr, wr_addr_r;
    logic [23:0] wr_data, wr_data_r;
    logic        commit, commit_r;
    logic [7:0]  brightness, brightness_r;
    logic        frame_busy, frame_busy_r;
    logic        commit_pending, commit_pending_r;

    int errors = 0;
    int checks = 0;

`ifdef FEEDER_BRIGHTNESS_EN
    localparam logic [23:0] BR_EXP = 24'h7F4020;
`else
    localparam logic [23:0] BR_EXP = 24'hFF8040;
`endif

    pixel_frame_feeder_if p ();
    pixel_frame_feeder_if pr ();

    pixel_frame_feeder #(.NUM_LEDS(8), .GAP_CYCLES(20)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .brightness     (brightness),
        .pix            (p),
        .frame_busy     (frame_busy),
        .commit_pending (commit_pending)
    );

    pixel_frame_feeder #(.NUM_LEDS(8), .REFRESH_CYCLES(200), .GAP_CYCLES(20)) dut_r (
        .clk            (clk),
        .rst            (rst_r),
        .wr_en          (wr_en_r),
        .wr_addr        (wr_addr_r),
        .wr_data        (wr_data_r),
        .commit         (commit_r),
        .brightness     (brightness_r),
        .pix            (pr),
        .frame_busy     (frame_busy_r),
        .commit_pending (commit_pending_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (frame_busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_reached", {31'd0, frame_busy}, 32'd0);
    endtask

    task automatic wait_rise_r(output int n);
        n = 0;
        while (pr.pix_valid && n < 400) begin
            tick();
            n++;
        end
        while (!pr.pix_valid && n < 400) begin
            tick();
            n++;
        end
        check("r_frame_seen", {31'd0, pr.pix_valid}, 32'd1);
    endtask

    task automatic start_frame();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;  rst_r = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; brightness = 8'hFF;
        wr_en_r = 1'b0; wr_addr_r = '0; wr_data_r = '0; commit_r = 1'b0; brightness_r = 8'hFF;
        p.pix_ready = 1'b1;
        pr.pix_ready = 1'b1;
        repeat (2) tick();
        check("rst_valid", {31'd0, p.pix_valid}, 32'd0);
        check("rst_data", {8'd0, p.pix_data}, 32'd0);
        check("rst_last", {31'd0, p.pix_last}, 32'd0);
        check("rst_busy", {31'd0, frame_busy}, 32'd0);
        check("rst_cp", {31'd0, commit_pending}, 32'd0);
        rst = 1'b0; rst_r = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 24'(i + 1);
            wr_en_r = 1'b1; wr_addr_r = 3'(i); wr_data_r = 24'(i + 1);
            tick();
        end
        wr_en = 1'b0; wr_en_r = 1'b0;

        // Basic frame: latency, order, pix_last, gap length
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("lat_n1_valid", {31'd0, p.pix_valid}, 32'd0);
        check("lat_n1_busy", {31'd0, frame_busy}, 32'd1);
        check("cp_set", {31'd0, commit_pending}, 32'd1);
        tick();
        check("lat_n2_valid", {31'd0, p.pix_valid}, 32'd1);
        check("cp_clear", {31'd0, commit_pending}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            check("f1_data", {8'd0, p.pix_data}, 32'(b + 1));
            check("f1_last", {31'd0, p.pix_last}, {31'd0, b == 7});
            tick();
        end
        check("f1_valid_low", {31'd0, p.pix_valid}, 32'd0);
        check("f1_gap_busy", {31'd0, frame_busy}, 32'd1);
        wait_idle(n);
        check("gap_len", n, 32'd20);

        // Backpressure on beat 3
        start_frame();
        for (int b = 0; b < 8; b++) begin
            check("stall_beat", {8'd0, p.pix_data}, 32'(b + 1));
            if (b == 2) begin
                p.pix_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check("stall_hold", {8'd0, p.pix_data}, 32'h3);
                    check("stall_valid", {31'd0, p.pix_valid}, 32'd1);
                end
                p.pix_ready = 1'b1;
            end
            tick();
        end
        check("stall_end", {31'd0, p.pix_valid}, 32'd0);
        wait_idle(n);

        // Write in the LATCH cycle: copy sees the old contents
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'hABCDEF;
        tick();
        wr_en = 1'b0;
        check("latchwr_px0", {8'd0, p.pix_data}, 32'h1);
        tick();
        check("latchwr_px1_old", {8'd0, p.pix_data}, 32'h2);
        wait_idle(n);
        start_frame();
        tick();
        check("latchwr_px1_new", {8'd0, p.pix_data}, 32'hABCDEF);
        wait_idle(n);

        // Brightness
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hFF8040;
        tick();
        wr_en = 1'b0;
        brightness = 8'h7F;
        start_frame();
        check("bright_px0", {8'd0, p.pix_data}, {8'd0, BR_EXP});
        brightness = 8'hFF;
        wait_idle(n);

        // Reset mid-stream on beat 4
        start_frame();
        repeat (3) tick();
        check("rst_beat4", {8'd0, p.pix_data}, 32'h4);
        rst = 1'b1;
        tick();
        check("midrst_valid", {31'd0, p.pix_valid}, 32'd0);
        check("midrst_data", {8'd0, p.pix_data}, 32'd0);
        check("midrst_last", {31'd0, p.pix_last}, 32'd0);
        check("midrst_busy", {31'd0, frame_busy}, 32'd0);
        rst = 1'b0;
        tick();
        start_frame();
        for (int b = 0; b < 8; b++) begin
            check("zero_data", {8'd0, p.pix_data}, 32'd0);
            check("zero_last", {31'd0, p.pix_last}, {31'd0, b == 7});
            tick();
        end
        wait_idle(n);

        // Short-refresh instance: commit frame, then refresh frames keep old data
        commit_r = 1'b1;
        tick();
        commit_r = 1'b0;
        wait_rise_r(n);
        check("r_commit_px0", {8'd0, pr.pix_data}, 32'h1);
        wait_rise_r(n);
        check("r_refresh_px0", {8'd0, pr.pix_data}, 32'h1);
        wr_en_r = 1'b1; wr_addr_r = 3'd0; wr_data_r = 24'hFF0000;
        tick();
        wr_en_r = 1'b0;
        for (int b = 1; b < 8; b++) begin
            check("r_beat", {8'd0, pr.pix_data}, 32'(b + 1));
            check("r_last", {31'd0, pr.pix_last}, {31'd0, b == 7});
            if (b < 7) tick();
        end
        wait_rise_r(n);
        check("r_period", 32'(7 + n), 32'd200);
        check("r_gap_ok", {31'd0, (n - 1) >= 20}, 32'd1);
        check("r_next_old", {8'd0, pr.pix_data}, 32'h1);
        commit_r = 1'b1;
        tick();
        commit_r = 1'b0;
        wait_rise_r(n);
        check("r_commit_new", {8'd0, pr.pix_data}, 32'hFF0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pixel_frame_feeder.md
PIXEL_FRAME_FEEDER -- requirements
Module: pixel_frame_feeder

Interface
REQ-001 Parameter NUM_LEDS, default 8, pixels per frame (legal 2..64).
REQ-002 Parameter REFRESH_CYCLES, default 1_666_666, clk cycles between automatic frame starts (~30 Hz at 50 MHz).
REQ-003 Parameter GAP_CYCLES, default 2500, minimum idle cycles after the last pixel (50 us latch gap at 50 MHz).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  write strobe into back buffer.
REQ-007 wr_addr  in  clog2(NUM_LEDS)  pixel index for write.
REQ-008 wr_data  in  24  pixel colour, GRB order, G in [23:16].
REQ-009 commit  in  1  one-cycle pulse requesting back-to-active buffer copy.
REQ-010 brightness  in  8  global brightness (used only with FEEDER_BRIGHTNESS_EN).
REQ-011 pix_valid  out  1  pixel available to downstream serializer.
REQ-012 pix_data  out  24  pixel colour, GRB.
REQ-013 pix_last  out  1  current pixel is index NUM_LEDS-1.
REQ-014 pix_ready  in  1  downstream accepts pixel when high with pix_valid.
REQ-015 frame_busy  out  1  high in LATCH, STREAM, GAP.
REQ-016 commit_pending  out  1  commit received, copy not yet done.

Function
REQ-017 Two NUM_LEDS x 24 arrays SHALL exist: back (written) and active (streamed).
REQ-018 wr_en SHALL write back[wr_addr] on the same edge in any state; wr_addr >= NUM_LEDS SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, LATCH, STREAM, GAP.
REQ-020 Free-running refresh counter 0..REFRESH_CYCLES-1 SHALL set refresh_pending on wrap; refresh_pending collapses multiple wraps into one.
REQ-021 IDLE -> LATCH when refresh_pending or commit_pending is high; both SHALL be cleared in LATCH.
REQ-022 LATCH SHALL copy all of back to active in one cycle iff commit_pending, zero the pixel index, register brightness, then go to STREAM.
REQ-023 commit arriving in the LATCH cycle SHALL leave commit_pending set (not lost).
REQ-024 STREAM: pix_valid=1, pix_data=active[idx] (scaled per REQ-033), pix_last=(idx==NUM_LEDS-1).
REQ-025 pix_data/pix_last SHALL stay stable while pix_valid && !pix_ready.
REQ-026 On pix_valid && pix_ready: idx increments, or on last pixel go to GAP with pix_valid low next cycle.
REQ-027 GAP SHALL count GAP_CYCLES cycles then return to IDLE; no frame starts during GAP.
REQ-028 Latency: commit in IDLE at cycle N -> LATCH at N+1 -> pix_valid high at N+2.
REQ-029 Writes during STREAM SHALL NOT alter the frame in flight.
REQ-030 Simultaneous wr_en and copy in LATCH: copy uses back contents before the write.

Reset
REQ-031 On rst: state IDLE, pix_valid=0, pix_data=0, pix_last=0, frame_busy=0, commit_pending=0, refresh_pending=0, counters 0, both arrays all-zero.
REQ-032 rst mid-STREAM SHALL drop pix_valid on the same edge; no partial-frame resume.

Configuration
REQ-033 With FEEDER_BRIGHTNESS_EN defined: each 8-bit channel of pix_data = (c * (bright_q + 1)) >> 8, bright_q registered in LATCH; without it, brightness is ignored and pix_data = active[idx] unmodified. Latency identical both ways.

Structure
REQ-034 Package ws2812_pkg SHALL hold GRB field bit positions, default GAP_CYCLES/REFRESH_CYCLES constants, and the FSM state type.
REQ-035 Sub-module pixel_scaler (combinational, 24-bit colour + 8-bit brightness -> 24-bit) SHALL implement REQ-033, instantiated only when macro defined.

Verification
REQ-036 Write 8 pixels 0x000001..0x000008, commit, pix_ready=1 -> pix_valid at commit+2, 8 beats in order, pix_last on beat 8 only.
REQ-037 pix_ready low for 5 cycles on beat 3 -> pix_data holds 0x000003 stable, no beat skipped or repeated.
REQ-038 Write pixel 0 = 0xFF0000 during STREAM without commit -> current and next refresh frame show old value; after commit, 0xFF0000.
REQ-039 REFRESH_CYCLES=200, no commit -> frames every 200 cycles, at least GAP_CYCLES low between pix_last beat and next pix_valid.
REQ-040 rst asserted on beat 4 -> pix_valid 0 after edge, all outputs 0, next frame streams all-zero pixels.
REQ-041 FEEDER_BRIGHTNESS_EN, brightness=0x7F, pixel 0xFF8040 -> pix_data 0x7F4020; macro undefined -> 0xFF8040.
